// File: rtl/booth_mult_sequencer.sv
// booth_mult_sequencer: FIFO-buffered operand feeder and product collector for a Booth multiplier.
// Optional BOOTH_SEQ_ZERO_BYPASS_EN returns 0 for zero operands without starting the multiplier.
module booth_mult_sequencer #(
  parameter int WIDTH      = 8,
  parameter int PROD_W     = 2*WIDTH-1,
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_mplier,
  input  logic [WIDTH-1:0]                in_mcand,
  output logic                            mul_st,
  output logic [WIDTH-1:0]                mul_mplier,
  output logic [WIDTH-1:0]                mul_mcand,
  input  logic [PROD_W-1:0]               mul_product,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PROD_W-1:0]               out_product,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(LATENCY+1);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, OUT} state_t;
  state_t                state_q, state_d;
  logic [2*WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic [CW-1:0]         lat_q, lat_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d, mcand_q, mcand_d;
  logic                  st_q, st_d, ov_q, ov_d;
  logic [PROD_W-1:0]     prod_q, prod_d;
  logic                  push, pop, empty;
  assign in_ready    = (cnt_q != (AW+1)'(FIFO_DEPTH)) && !rst;
  assign push        = in_valid && in_ready;
  assign empty       = cnt_q == '0;
  assign mul_st      = st_q;
  assign mul_mplier  = mplier_q;
  assign mul_mcand   = mcand_q;
  assign out_valid   = ov_q;
  assign out_product = prod_q;
  assign busy        = state_q != IDLE;
  assign fifo_count  = cnt_q;
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    ov_d     = ov_q;
    prod_d   = prod_q;
    st_d     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        pop     = !empty;
        state_d = empty ? IDLE : LOAD;
      end
      LOAD: begin
`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
        if (mplier_q == '0 || mcand_q == '0) begin
          prod_d  = '0;
          ov_d    = 1'b1;
          state_d = OUT;
        end else begin
          st_d    = 1'b1;
          state_d = START;
        end
`else
        st_d    = 1'b1;
        state_d = START;
`endif
      end
      START: begin
        lat_d   = CW'(LATENCY-1);
        state_d = WAIT;
      end
      WAIT: begin
        lat_d   = (lat_q == '0) ? lat_q : lat_q - CW'(1);
        prod_d  = (lat_q == '0) ? mul_product : prod_q;
        ov_d    = lat_q == '0;
        state_d = (lat_q == '0) ? OUT : WAIT;
      end
      OUT: begin
        pop     = out_ready && !empty;
        ov_d    = !out_ready;
        state_d = !out_ready ? OUT : (empty ? IDLE : LOAD);
      end
      default: state_d = IDLE;
    endcase
    // popped pair goes straight into the operand registers, held until the next pop
    {mplier_d, mcand_d} = pop ? mem_q[rd_q] : {mplier_d, mcand_d};
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      lat_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      st_q     <= 1'b0;
      ov_q     <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      st_q     <= st_d;
      ov_q     <= ov_d;
      prod_q   <= prod_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {in_mplier, in_mcand};
  end
endmodule

// File: tb/tb_booth_mult_sequencer.sv
// tb_booth_mult_sequencer: scoreboard bench with a latency-accurate multiplier stand-in.
module tb_booth_mult_sequencer;
  localparam int LAT = 10;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_ready = 1'b1;
  logic [7:0]  in_mplier = '0, in_mcand = '0, mul_mplier, mul_mcand;
  logic        mul_st, out_valid, busy;
  logic [14:0] mul_product, out_product;
  logic [2:0]  fifo_count;
  int          n_chk = 0, n_fail = 0, st_cnt = 0, k = 0;
  logic        st_prev = 1'b0;
  typedef struct {logic [7:0] a; logic [7:0] b; logic [14:0] p;} exp_t;
  exp_t        sb[$];

  booth_mult_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mplier(in_mplier), .in_mcand(in_mcand), .mul_st(mul_st),
    .mul_mplier(mul_mplier), .mul_mcand(mul_mcand), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // multiplier stand-in: output is junk until LAT clocks after the mul_st cycle
  always @(posedge clk) begin
    logic signed [15:0] full;
    full = $signed(mul_mplier) * $signed(mul_mcand);
    if (rst) begin
      k <= 0;
      mul_product <= 15'h2AAA;
    end else if (mul_st) begin
      k <= LAT - 1;
      mul_product <= 15'h2AAA;
    end else if (k == 1) begin
      k <= 0;
      mul_product <= full[14:0];
    end else if (k != 0) k <= k - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compares every result handshake against the scoreboard
  always @(negedge clk) begin
    if (!rst && mul_st) begin
      st_cnt++;
      if (st_prev) check("mul_st_width", 32'd2, 32'd1);
    end
    st_prev = mul_st;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_result", {17'd0, out_product}, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("out_product", {17'd0, out_product}, {17'd0, e.p});
        check("operands", {16'd0, mul_mplier, mul_mcand}, {16'd0, e.a, e.b});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [14:0] p, input bit exp = 1'b1);
    int i;
    in_valid = 1'b1; in_mplier = a; in_mcand = b;
    for (i = 0; i < 100 && !in_ready; i++) cyc(1);
    if (!in_ready) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (exp) sb.push_back('{a, b, p});
    in_valid = 1'b0;
  endtask

  task automatic latency(input string name, input int exp);
    int n;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      cyc(1);
      if (out_valid) n = i;
    end
    check(name, n, exp);
  endtask

  task automatic drain;
    int i;
    for (i = 0; i < 300 && (sb.size() != 0 || busy); i++) cyc(1);
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int s0;
    cyc(2);
    check("rst_in_ready", in_ready, 0);
    check("rst_outs", {out_valid, mul_st, busy, fifo_count}, 0);
    check("rst_data", {out_product, mul_mplier, mul_mcand}, 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);
    check("rel_count", fifo_count, 0);
    cyc(1);

    s0 = st_cnt;
    push(8'hA6, 8'h66, 15'h5C24);
    latency("lat_basic", 13);
    check("out_basic", out_product, 15'h5C24);
    drain();
    check("st_pulses_basic", st_cnt - s0, 1);

    out_ready = 1'b0;
    push(8'h66, 8'h33, 15'h1452);
    push(8'h02, 8'h03, 15'h0006);
    latency("lat_hold", 12);
    s0 = st_cnt;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("hold_valid", out_valid, 1);
      check("hold_product", out_product, 15'h1452);
      check("hold_count", fifo_count, 1);
    end
    check("hold_no_start", st_cnt - s0, 0);
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    push(8'h03, 8'h04, 15'h000C);
    push(8'hFF, 8'hFF, 15'h0001);
    push(8'h80, 8'h7F, 15'h4080);
    push(8'h7F, 8'h7F, 15'h3F01);
    push(8'hFB, 8'h07, 15'h7FDD);
    check("full_count", fifo_count, 4);
    check("full_in_ready", in_ready, 0);
    cyc(20);
    check("full_in_ready_later", in_ready, 0);
    out_ready = 1'b1;
    drain();

    push(8'h09, 8'h09, 15'h0051, 1'b0);
    cyc(6);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mid_rst_state", {out_valid, mul_st, busy, fifo_count}, 0);
    cyc(20);
    check("mid_rst_idle", {out_valid, busy}, 0);
    push(8'h07, 8'hFD, 15'h7FEB);
    latency("lat_after_rst", 13);
    drain();

    s0 = st_cnt;
    push(8'h00, 8'h7F, 15'h0000);
`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
    latency("lat_zero", 2);
    check("out_zero", out_product, 0);
    drain();
    check("st_pulses_zero", st_cnt - s0, 0);
`else
    latency("lat_zero", 13);
    check("out_zero", out_product, 0);
    drain();
    check("st_pulses_zero", st_cnt - s0, 1);
`endif
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
